// File: rtl/sa_pkg.sv
// Shared types, default sizes and the column-sum reduction for the systolic array.
// Build option SA_SAT_EN: saturate column sums instead of wrapping them.
package sa_pkg;

    localparam int unsigned SA_N_DEF      = 3;
    localparam int unsigned SA_DATA_W_DEF = 8;
    localparam int unsigned SA_ACC_W_DEF  = 20;
    localparam int unsigned SA_OUT_W_DEF  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain
    } sa_state_e;

    // Reduces a sign-extended sum to out_w bits, returned sign-extended; the caller keeps the low bits.
    function automatic logic signed [63:0] sa_reduce(input logic signed [63:0] acc,
                                                     input int unsigned out_w);
`ifdef SA_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) return hi;
        if (acc < lo) return lo;
`endif
        return (acc <<< (64 - out_w)) >>> (64 - out_w);
    endfunction

endpackage

// File: rtl/sa_pe.sv
// One weight-stationary cell: held weight, east-passing activation and a registered MAC
// whose partial sum moves south.
module sa_pe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 20
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_w_we,
    input  logic signed [DATA_W-1:0] i_w,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [ACC_W-1:0]  i_psum,
    output logic signed [DATA_W-1:0] o_a,
    output logic signed [ACC_W-1:0]  o_psum
);

    logic signed [DATA_W-1:0]   r_w;
    logic signed [DATA_W-1:0]   r_a;
    logic signed [ACC_W-1:0]    r_psum;
    logic signed [2*DATA_W-1:0] w_prod;

    assign w_prod = i_a * r_w;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_w    <= '0;
            r_a    <= '0;
            r_psum <= '0;
        end else begin
            if (i_w_we) r_w <= i_w;
            r_a    <= i_a;
            r_psum <= i_psum + ACC_W'(w_prod);
        end
    end

    assign o_a    = r_a;
    assign o_psum = r_psum;

endmodule

// File: rtl/sa_array.sv
// N x N weight-stationary systolic matrix-vector engine: y[c] = sum_r a[r] * W[r][c].
// Build option SA_SAT_EN selects saturating output reduction (see sa_pkg::sa_reduce).
module sa_array
    import sa_pkg::*;
#(
    parameter int unsigned N      = SA_N_DEF,
    parameter int unsigned DATA_W = SA_DATA_W_DEF,
    parameter int unsigned ACC_W  = SA_ACC_W_DEF,
    parameter int unsigned OUT_W  = SA_OUT_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_w_load,
    input  logic                  i_w_row_valid,
    input  logic [N*DATA_W-1:0]   i_w_row,
    input  logic                  i_start,
    input  logic                  i_a_valid,
    output logic                  o_a_ready,
    input  logic                  i_a_last,
    input  logic [N*DATA_W-1:0]   i_a_vec,
    output logic                  o_y_valid,
    output logic [N*OUT_W-1:0]    o_y_vec,
    output logic                  o_w_ok,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(2 * N) : 1;
    localparam int unsigned VLD_D = 2 * N - 1;

    sa_state_e         r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic              r_w_ok, w_w_ok_d;
    logic              r_done, w_done_d;
    logic              w_hs;
    logic [VLD_D-1:0]  r_vld;
    logic              r_y_valid;
    logic [N*OUT_W-1:0] r_y_vec;

    logic signed [DATA_W-1:0] w_a_in [N];
    logic signed [DATA_W-1:0] w_ah   [N][N+1];
    logic signed [ACC_W-1:0]  w_ps   [N+1][N];
    logic signed [ACC_W-1:0]  w_col  [N];
    logic [N-1:0]             w_we;

    assign o_a_ready = (r_state == StRun);
    assign w_hs      = i_a_valid && o_a_ready;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_w_ok_d  = r_w_ok;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (i_w_load) begin
                    w_state_d = StLoad;
                    w_w_ok_d  = 1'b0;
                end else if (i_start && r_w_ok) begin
                    w_state_d = StRun;
                end
            end
            StLoad: begin
                if (i_w_row_valid) begin
                    if (r_cnt == CNT_W'(N - 1)) begin
                        w_state_d = StIdle;
                        w_w_ok_d  = 1'b1;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            StRun: begin
                if (w_hs && i_a_last) begin
                    w_state_d = StDrain;
                    w_cnt_d   = '0;
                end
            end
            StDrain: begin
                // Stay until the last vector has left the output register.
                if (r_cnt == CNT_W'(2 * N - 1)) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_w_ok  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_w_ok  <= w_w_ok_d;
            r_done  <= w_done_d;
        end
    end

    always_comb begin
        for (int r = 0; r < N; r++) begin
            w_a_in[r] = w_hs ? signed'(i_a_vec[r*DATA_W +: DATA_W]) : '0;
            w_we[r]   = (r_state == StLoad) && i_w_row_valid && (r_cnt == CNT_W'(r));
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign w_ah[r][0] = w_a_in[r];
        end else begin : g_pipe
            logic signed [DATA_W-1:0] r_sk [r];
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int k = 0; k < r; k++) r_sk[k] <= '0;
                end else begin
                    r_sk[0] <= w_a_in[r];
                    for (int k = 1; k < r; k++) r_sk[k] <= r_sk[k-1];
                end
            end
            assign w_ah[r][0] = r_sk[r-1];
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_top
        assign w_ps[0][c] = '0;
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            sa_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_w_we (w_we[r]),
                .i_w    (signed'(i_w_row[c*DATA_W +: DATA_W])),
                .i_a    (w_ah[r][c]),
                .i_psum (w_ps[r][c]),
                .o_a    (w_ah[r][c+1]),
                .o_psum (w_ps[r+1][c])
            );
        end
    end

    // Column c leaves the grid N-1-c cycles ahead of the last column.
    for (genvar c = 0; c < N; c++) begin : g_deskew
        if (c == N - 1) begin : g_direct
            assign w_col[c] = w_ps[N][c];
        end else begin : g_pipe
            localparam int unsigned D = N - 1 - c;
            logic signed [ACC_W-1:0] r_ds [D];
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int k = 0; k < D; k++) r_ds[k] <= '0;
                end else begin
                    r_ds[0] <= w_ps[N][c];
                    for (int k = 1; k < D; k++) r_ds[k] <= r_ds[k-1];
                end
            end
            assign w_col[c] = r_ds[D-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld     <= '0;
            r_y_valid <= 1'b0;
            r_y_vec   <= '0;
        end else begin
            r_vld     <= (r_vld << 1) | VLD_D'(w_hs);
            r_y_valid <= r_vld[VLD_D-1];
            for (int c = 0; c < N; c++) begin
                r_y_vec[c*OUT_W +: OUT_W] <= OUT_W'(sa_reduce(64'(w_col[c]), OUT_W));
            end
        end
    end

    assign o_y_valid = r_y_valid;
    assign o_y_vec   = r_y_vec;
    assign o_w_ok    = r_w_ok;
    assign o_busy    = (r_state != StIdle);
    assign o_done    = r_done;

endmodule

// File: tb/tb_sa_array.sv
// Directed self-checking bench for sa_array (N=3, DATA_W=8, OUT_W=8).
module tb_sa_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_load = 1'b0;
    logic        w_row_valid = 1'b0;
    logic [23:0] w_row = '0;
    logic        start = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_last = 1'b0;
    logic [23:0] a_vec = '0;
    logic        a_ready;
    logic        y_valid;
    logic [23:0] y_vec;
    logic        w_ok;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    logic [23:0] yq [$];
    int          ycq [$];
    int          dq [$];

    sa_array #(
        .N      (3),
        .DATA_W (8),
        .ACC_W  (20),
        .OUT_W  (8)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_w_load      (w_load),
        .i_w_row_valid (w_row_valid),
        .i_w_row       (w_row),
        .i_start       (start),
        .i_a_valid     (a_valid),
        .o_a_ready     (a_ready),
        .i_a_last      (a_last),
        .i_a_vec       (a_vec),
        .o_y_valid     (y_valid),
        .o_y_vec       (y_vec),
        .o_w_ok        (w_ok),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pk(input int e0, input int e1, input int e2);
        logic [7:0] b0, b1, b2;
        b0 = e0[7:0];
        b1 = e1[7:0];
        b2 = e2[7:0];
        return {b2, b1, b0};
    endfunction

    function automatic logic [31:0] qy(input int i);
        return (yq.size() > i) ? {8'h00, yq[i]} : 32'hdead_beef;
    endfunction

    function automatic int qc(input int i);
        return (ycq.size() > i) ? ycq[i] : -1000;
    endfunction

    function automatic int qd(input int i);
        return (dq.size() > i) ? dq[i] : -1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (y_valid) begin
            yq.push_back(y_vec);
            ycq.push_back(cyc);
        end
        if (done) dq.push_back(cyc);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        yq.delete();
        ycq.delete();
        dq.delete();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [23:0] r0, input logic [23:0] r1, input logic [23:0] r2);
        w_load = 1'b1;
        tick();
        w_load      = 1'b0;
        w_row_valid = 1'b1;
        w_row       = r0;
        tick();
        w_row = r1;
        tick();
        w_row = r2;
        tick();
        w_row_valid = 1'b0;
        w_row       = '0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_a_ready"}, {31'd0, a_ready}, 32'd0);
        check({tag, "_y_valid"}, {31'd0, y_valid}, 32'd0);
        check({tag, "_y_vec"}, {8'd0, y_vec}, 32'd0);
        check({tag, "_w_ok"}, {31'd0, w_ok}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        ticks(2);
        reset_vals("rst");
        rst = 1'b0;
        tick();

        // start without weights is ignored
        go();
        check("start_no_w_busy", {31'd0, busy}, 32'd0);

        // identity load, with a gap between rows
        w_load = 1'b1;
        tick();
        w_load = 1'b0;
        check("load_busy", {31'd0, busy}, 32'd1);
        w_row_valid = 1'b1;
        w_row = pk(1, 0, 0);
        tick();
        w_row = pk(0, 1, 0);
        tick();
        w_row_valid = 1'b0;
        ticks(2);
        check("load_gap_w_ok", {31'd0, w_ok}, 32'd0);
        w_row_valid = 1'b1;
        w_row = pk(0, 0, 1);
        tick();
        w_row_valid = 1'b0;
        check("load_w_ok", {31'd0, w_ok}, 32'd1);
        check("load_idle", {31'd0, busy}, 32'd0);

        go();
        check("run_ready", {31'd0, a_ready}, 32'd1);
        clr();
        a_valid = 1'b1; a_vec = pk(1, 2, 3); a_last = 1'b1;
        tick();
        t0 = cyc;
        a_valid = 1'b0; a_last = 1'b0;
        check("drain_ready", {31'd0, a_ready}, 32'd0);
        ticks(8);
        check("id_count", yq.size(), 32'd1);
        check("id_y", qy(0), {8'd0, pk(1, 2, 3)});
        check("id_latency", qc(0) - t0, 32'd5);
        check("id_done", qd(0) - t0, 32'd6);
        check("id_done_count", dq.size(), 32'd1);
        check("id_idle", {31'd0, busy}, 32'd0);

        // all-ones weights, three vectors back to back
        load(pk(1, 1, 1), pk(1, 1, 1), pk(1, 1, 1));
        go();
        clr();
        a_valid = 1'b1; a_vec = pk(1, 1, 1);
        tick();
        t0 = cyc;
        a_vec = pk(2, 0, -1);
        tick();
        a_vec = pk(-3, -3, -3); a_last = 1'b1;
        tick();
        a_valid = 1'b0; a_last = 1'b0;
        ticks(8);
        check("ones_count", yq.size(), 32'd3);
        check("ones_y0", qy(0), {8'd0, pk(3, 3, 3)});
        check("ones_y1", qy(1), {8'd0, pk(1, 1, 1)});
        check("ones_y2", qy(2), {8'd0, pk(-9, -9, -9)});
        check("ones_lat0", qc(0) - t0, 32'd5);
        check("ones_lat1", qc(1) - t0, 32'd6);
        check("ones_lat2", qc(2) - t0, 32'd7);
        check("ones_done", qd(0) - t0, 32'd8);

        // asymmetric weights, valid bubbles 1,0,0,1 and a w_load attempt during RUN
        load(pk(1, 2, 3), pk(4, 5, 6), pk(7, 8, 9));
        go();
        clr();
        a_valid = 1'b1; a_vec = pk(2, 1, 1);
        tick();
        t0 = cyc;
        a_valid = 1'b0;
        w_load = 1'b1; w_row_valid = 1'b1; w_row = '0;
        tick();
        w_load = 1'b0; w_row_valid = 1'b0;
        check("wload_run_busy", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b1; a_vec = pk(0, 1, -1); a_last = 1'b1;
        tick();
        a_valid = 1'b0; a_last = 1'b0;
        ticks(8);
        check("bub_count", yq.size(), 32'd2);
        check("bub_y0", qy(0), {8'd0, pk(13, 17, 21)});
        check("bub_y1", qy(1), {8'd0, pk(-3, -3, -3)});
        check("bub_lat0", qc(0) - t0, 32'd5);
        check("bub_lat1", qc(1) - t0, 32'd8);
        check("wload_run_w_ok", {31'd0, w_ok}, 32'd1);

        go();
        clr();
        a_valid = 1'b1; a_vec = pk(1, 0, 0); a_last = 1'b1;
        tick();
        a_valid = 1'b0; a_last = 1'b0;
        ticks(8);
        check("w_keep_y", qy(0), {8'd0, pk(1, 2, 3)});

        // w_load and start together: load wins
        w_load = 1'b1; start = 1'b1;
        tick();
        w_load = 1'b0; start = 1'b0;
        check("both_busy", {31'd0, busy}, 32'd1);
        check("both_w_ok", {31'd0, w_ok}, 32'd0);
        check("both_ready", {31'd0, a_ready}, 32'd0);
        w_row_valid = 1'b1;
        w_row = pk(127, 127, 127);
        ticks(3);
        w_row_valid = 1'b0;
        check("big_w_ok", {31'd0, w_ok}, 32'd1);

        go();
        clr();
        a_valid = 1'b1; a_vec = pk(127, 127, 127);
        tick();
        a_vec = pk(-128, -128, -128); a_last = 1'b1;
        tick();
        a_valid = 1'b0; a_last = 1'b0;
        ticks(8);
`ifdef SA_SAT_EN
        check("big_pos", qy(0), {8'd0, pk(127, 127, 127)});
`else
        check("big_pos", qy(0), {8'd0, pk(3, 3, 3)});
`endif
        check("big_neg", qy(1), {8'd0, pk(-128, -128, -128)});

        // reset two cycles after an accepted vector
        go();
        clr();
        a_valid = 1'b1; a_vec = pk(1, 1, 1);
        tick();
        a_valid = 1'b0;
        ticks(2);
        rst = 1'b1;
        #1;
        reset_vals("midrst");
        ticks(2);
        rst = 1'b0;
        ticks(8);
        check("midrst_no_y", yq.size(), 32'd0);
        check("midrst_no_done", dq.size(), 32'd0);
        go();
        check("midrst_start_ignored", {31'd0, busy}, 32'd0);
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sa_array.md
# sa_array

Parametrised weight-stationary N×N systolic matrix-vector engine. It generalises the fixed 3×3 8-bit array to configurable size and width. It adds a weight-load FSM, streaming activations with valid/ready, internal input skew and output de-skew, a wide accumulator, and a drain phase. Each accepted activation vector `a` produces one aligned output vector `y[c] = Σr a[r]·W[r][c]`. It sits between the activation buffer and the post-processing/adder stage of the compute datapath.

## Interface
- `N`, 3, array rows = columns = vector length
- `DATA_W`, 8, signed two's-complement activation/weight width
- `ACC_W`, 20, internal partial-sum width (must be ≥ 2·DATA_W + clog2(N))
- `OUT_W`, 8, signed output element width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `w_load`  in  1  pulse in IDLE: begin weight load
- `w_row_valid`  in  1  `w_row` valid this cycle (LOAD only)
- `w_row`  in  N·DATA_W  one weight row; element c at bits [c·DATA_W +: DATA_W]
- `start`  in  1  pulse in IDLE: begin compute run
- `a_valid`  in  1  activation vector valid
- `a_ready`  out  1  array accepts a vector
- `a_last`  in  1  marks final vector of run (qualified by a_valid & a_ready)
- `a_vec`  in  N·DATA_W  activation vector, element r = row r
- `y_valid`  out  1  `y_vec` valid (single cycle per vector, no backpressure)
- `y_vec`  out  N·OUT_W  result vector, element c = column c
- `w_ok`  out  1  complete weight set held
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at end of DRAIN

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN.
  - IDLE: `w_load` goes to LOAD and clears `w_ok`. Otherwise `start` with `w_ok=1` goes to RUN. `start` with `w_ok=0` is ignored. If `w_load` and `start` arrive in the same cycle, `w_load` wins.
  - LOAD: each `w_row_valid` writes row counter k (0..N-1) into PE(k,c).weight. After row N-1, go to IDLE and set `w_ok=1`. Gaps in `w_row_valid` are allowed.
  - RUN: `a_ready=1`. A handshake (`a_valid & a_ready`) injects the vector. A handshake with `a_last=1` goes to DRAIN.
  - DRAIN: `a_ready=0` for 2N-1 cycles (counter), then pulse `done` and go to IDLE.
- `w_load` and `start` are ignored outside IDLE. Weights persist across runs until the next LOAD or reset.
- Dataflow:
  - Activation row r is skewed by r cycles, then moves east one PE per cycle.
  - Partial sums move south; the top row's psum input is 0.
  - Column c output is de-skewed by N-1-c cycles.
- A valid bit travels with the data through the skew/de-skew pipes, so bubbles on `a_valid` produce matching bubbles on `y_valid`.
- Arithmetic:
  - Products are signed 2·DATA_W bits, sign-extended to ACC_W before accumulation.
  - There is no wrap inside ACC_W given the parameter rule.
  - ACC_W→OUT_W reduction follows Configuration.

## Timing
- Reset values: `a_ready=0`, `y_valid=0`, `y_vec=0`, `w_ok=0`, `busy=0`, `done=0`. State is IDLE. All weights, skew, psum and de-skew registers are 0.
- Compute latency: a vector accepted at edge t gives `y_valid=1` in the cycle after edge t+2N-1 (5 cycles for N=3). Throughput is 1 vector/cycle.
- `done` is asserted the cycle after the last vector's `y_valid` cycle.
- LOAD takes exactly N `w_row_valid` cycles. `w_ok` rises the cycle after the last row.
- Reset mid-LOAD/RUN/DRAIN aborts immediately. In-flight results are discarded, no `y_valid` or `done` is produced, and `w_ok=0`.

## Configuration
- `SA_SAT_EN` defined: each column sum is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: `y_vec` element = low OUT_W bits of the sum (two's-complement wrap).

## Structure
- Package `sa_pkg`: FSM state enum, default parameter constants, and the saturate/truncate function.
- Sub-module `sa_pe` handles one cell:
  - weight register with write enable
  - east-pass activation register
  - registered MAC: psum_out = psum_in + a·w
- `sa_array` contains the FSM, counters, skew/de-skew shift registers, valid pipe, N×N `sa_pe` generate grid, and output reduction.

## Test plan
- W = identity, start, a=(1,2,3) accepted at t → y=(1,2,3), `y_valid` 5 cycles later, `done` next cycle.
- W all 1, vectors (1,1,1),(2,0,-1),(−3,−3,−3) back-to-back → y=(3,3,3),(1,1,1),(−9,−9,−9) on consecutive cycles.
- W all 127, a=(127,127,127): with `SA_SAT_EN`, y=(127,127,127); without, y=(3,3,3) (48387 mod 256). a=(−128)×3 with `SA_SAT_EN` → y=(−128,−128,−128).
- Random a_valid bubbles (e.g. valid 1,0,0,1) → `y_valid` pattern identical, delayed by 5 cycles.
- `start` with `w_ok=0` → stays IDLE. `w_load` asserted during RUN → ignored, weights unchanged. `w_load`+`start` together in IDLE → LOAD.
- `rst` asserted 2 cycles after a vector is accepted in RUN → all outputs at reset values, no `y_valid`, `w_ok=0`, and a later `start` is ignored until a reload.
